// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drain stage for the byte FIFO. Pops one byte at a time
// (show-ahead head byte) and sends it as an asynchronous UART frame:
// start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// A new byte is popped in the final stop cycle so frames run back to back.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   Enable     level, permits starting new frames
//   Fifo_Dout  FIFO head byte (valid while Fifo_Empty=0)
//   Fifo_Empty FIFO empty flag
//   Pop        combinational one-cycle FIFO pop strobe
//   Tx         registered serial line, idles high
//   Busy       registered, high for every cycle of a frame (aligned with Tx)
//   Done       one-cycle pulse in the last stop-bit cycle
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Enable,
    input  logic [7:0] Fifo_Dout,
    input  logic       Fifo_Empty,
    output logic       Pop,
    output logic       Tx,
    output logic       Busy,
    output logic       Done
);

    localparam int             PW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0]  CNT_MAX   = PW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    // State names the bit currently on the line.
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic          tx_d, busy_d;
    logic          launch, bit_end, last_stop;

    assign launch    = Enable & ~Fifo_Empty & ~RST;
    assign bit_end   = (cnt_q == CNT_MAX);
    assign last_stop = (state_q == STOP) && bit_end && (bit_q == STOP_LAST);

    assign Pop  = launch && ((state_q == IDLE) || last_stop);
    assign Done = last_stop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
            end
            START: begin
                tx_d  = 1'b0;
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                end
            end
            DATA: begin
                tx_d  = sh_q[0];
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Next bit is already sitting one position up.
                        sh_d  = sh_q >> 1;
                        bit_d = bit_q + 3'd1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            PARITY: begin
                tx_d  = par_q;
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                tx_d  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Capture overrides everything: the head byte is taken on the pop edge
        // and the start bit goes out the following cycle.
        if (Pop) begin
            state_d = START;
            cnt_d   = '0;
            bit_d   = '0;
            sh_d    = Fifo_Dout;
            par_d   = ^Fifo_Dout;
            tx_d    = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            Tx      <= 1'b1;
            Busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            Tx      <= tx_d;
            Busy    <= busy_d;
        end
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the 8-bit 12-entry byte FIFO. It pops one byte at a time from the FIFO and serialises it as an asynchronous UART frame on a single line: start bit, data LSB first, optional even parity, then stop bit(s). Back-to-back frames leave no idle gap while the FIFO has data. All timing derives from the single system clock through an internal bit-period counter.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
CLK  input  1  system clock; all logic is on the rising edge.
RST  input  1  synchronous, active-high reset.
Enable  input  1  level; permits starting new frames.
Fifo_Dout  input  8  FIFO head byte; valid whenever Fifo_Empty=0, show-ahead.
Fifo_Empty  input  1  FIFO empty flag.
Pop  output  1  one-cycle FIFO pop strobe; drives the FIFO Pop input.
Tx  output  1  serial line; idles high.
Busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.
Done  output  1  one-cycle pulse in the last stop-bit cycle of each frame.

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high. RST is sampled on the rising CLK edge. While RST=1 on an edge, the next state is: Tx=1, Busy=0, Done=0, state=IDLE, bit counter=0, period counter=0, shift register=0. Pop is forced to 0 combinationally whenever RST=1.
- States: IDLE, START, DATA, PARITY (only when PARITY_EN=1), STOP.
- Launch condition L = Enable & ~Fifo_Empty & ~RST.
- Pop is combinational. Pop=1 when L holds and either the state is IDLE, or the state is STOP in its final cycle. Pop is never high when Fifo_Empty=1.
- Capture: on the edge where Pop=1, Fifo_Dout loads into the 8-bit shift register, the state goes to START, and the period counter clears.
- Tx is registered. Tx goes low on the edge that ends the Pop cycle, so it is low in the cycle after Pop. Launch latency is 1 cycle.
- START: Tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. The register shifts right at each bit boundary.
- PARITY: Tx holds the XOR of the 8 captured bits (even parity) for CLKS_PER_BIT cycles.
- STOP: Tx=1 for STOP_BITS*CLKS_PER_BIT cycles. Done=1 in the final cycle.
- After the final STOP cycle: go to START if Pop fired in that cycle, otherwise go to IDLE.
- Frame length is (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles.
- Period counter: width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. The bit counter is 3 bits, counting 0..7.
- Busy=1 in START, DATA, PARITY and STOP. Busy is registered and aligned with Tx.
- Enable deasserted mid-frame: the current frame completes unchanged, and no further Pop occurs.
- Enable asserted while Fifo_Empty=1: remain in IDLE with Tx=1.
- Fifo_Empty rising mid-frame: no effect on the current frame.
- RST mid-frame: the frame aborts. Tx=1 from the cycle after the reset edge, and the byte is lost (not re-popped).
- Fifo_Dout changing after capture has no effect.

Test Plan:
- CLKS_PER_BIT=4, PARITY_EN=0; FIFO holds 0xA5; Enable=1 -> Pop high exactly 1 cycle. Tx is low the next cycle. Tx sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total). Done pulses once in cycle 40 of the frame, and Busy drops after it.
- Same configuration; FIFO holds 0x00 then 0xFF -> second Pop coincides with the Done cycle. The second start bit immediately follows the stop bit with no idle cycle. Exactly 2 Pops, 80 Busy cycles.
- Fifo_Empty=1, Enable=1 for 100 cycles -> Pop stays 0, Tx stays 1, Busy stays 0.
- FIFO holds 3 bytes; Enable drops in the 5th data bit of frame 1 -> frame 1 completes. Pop count is 1, Tx stays 1 afterwards, and 2 bytes remain.
- RST asserted for 1 cycle during bit 3 of a frame -> Tx=1, Busy=0, Pop=0 from the next cycle. With Enable=1 and data present, the next frame starts cleanly.
- PARITY_EN=1, STOP_BITS=2, byte 0x07 -> data 1,1,1,0,0,0,0,0; parity bit 1; 2 stop bits. Frame is 12*CLKS_PER_BIT cycles.
